// File: rtl/itype_control_unit_pkg.sv
// Shared definitions for the I-type issue/control engine.
//   - opcode values for the supported I-type instructions (match the ALU)
//   - FSM state encoding
//   - exception codes reported alongside retire
//   - helpers for opcode legality and immediate extension
package itype_control_unit_pkg;

    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] EXC_OK       = 2'd0;
    localparam logic [1:0] EXC_ILLEGAL  = 2'd1;
    localparam logic [1:0] EXC_OVERFLOW = 2'd2;
    localparam logic [1:0] EXC_BUS_TMO  = 2'd3;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    function automatic logic is_legal(input logic [5:0] op);
        logic legal;
        case (op)
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_LUI, OP_SLTI,
            OP_SLTIU, OP_BEQ, OP_BNE, OP_LW, OP_SW: legal = 1'b1;
            default:                                  legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Logical immediates are zero-extended, LUI places the field in the
    // upper half, everything else (arith, compare, branch, load/store)
    // is sign-extended.
    function automatic logic [31:0] extend_imm(input logic [5:0] op,
                                               input logic [15:0] imm);
        logic [31:0] ext;
        case (op)
            OP_ANDI, OP_ORI: ext = {16'h0000, imm};
            OP_LUI:          ext = {imm, 16'h0000};
            default:         ext = {{16{imm[15]}}, imm};
        endcase
        return ext;
    endfunction

endpackage

// File: rtl/itype_regfile.sv
// 32 x 32-bit register file for the I-type control engine.
//   clk, reset        : clock, asynchronous active-high clear of all registers
//   rs_addr/rs_data   : asynchronous read port A
//   rt_addr/rt_data   : asynchronous read port B
//   we/wr_addr/wr_data: synchronous write port (writes to $0 are dropped)
module itype_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_addr,
    output logic [31:0] rs_data,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rt_data,
    input  logic        we,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data
);

    logic [31:0] regs [32];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wr_addr != 5'd0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // $0 is hard-wired to zero regardless of array contents.
    assign rs_data = (rs_addr == 5'd0) ? 32'h0 : regs[rs_addr];
    assign rt_data = (rt_addr == 5'd0) ? 32'h0 : regs[rt_addr];

endmodule

// File: rtl/itype_control_unit.sv
// Multi-cycle issue/control engine driving an external I-type ALU.
// One instruction in flight: FETCH -> DECODE -> EXEC -> {MEM} -> {WB} -> FETCH.
//   clk, reset           : clock, asynchronous active-high reset
//   instr_valid/instr/instr_ready : instruction handshake (ready only in FETCH)
//   pc                   : address of the instruction being / next fetched
//   alu_opcode/rs/rt/imm : registered operands presented to the ALU during EXEC
//   alu_result/zero/overflow : combinational ALU response, sampled end of EXEC
//   mem_req/we/addr/wdata, mem_rdata/mem_ack : data memory port for LW/SW
//   retire/exc_code      : one-cycle completion pulse with exception code
module itype_control_unit
    import itype_control_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic [31:0] pc,
    output logic [5:0]  alu_opcode,
    output logic [31:0] alu_rs,
    output logic [31:0] alu_rt,
    output logic [31:0] alu_imm,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        retire,
    output logic [1:0]  exc_code
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t            state;
    state_t            state_next;
    logic [31:0]       ir;
    logic [31:0]       pc_next;
    logic              started;
    logic [31:0]       wb_data;
    logic [CNT_W-1:0]  wait_cnt;
    logic              rf_we;
    logic [31:0]       rd_rs;
    logic [31:0]       rd_rt;

    logic [5:0]  op;
    logic [4:0]  rs_idx;
    logic [4:0]  rt_idx;
    logic [15:0] imm16;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic        branch_taken;

    assign op       = ir[31:26];
    assign rs_idx   = ir[25:21];
    assign rt_idx   = ir[20:16];
    assign imm16    = ir[15:0];
    assign pc_plus4 = pc + 32'd4;

    // alu_imm already holds the sign-extended branch offset during EXEC.
    assign branch_target = pc_plus4 + {alu_imm[29:0], 2'b00};
    assign branch_taken  = (op == OP_BEQ) ? alu_zero : !alu_zero;

    itype_regfile u_regfile (
        .clk     (clk),
        .reset   (reset),
        .rs_addr (rs_idx),
        .rs_data (rd_rs),
        .rt_addr (rt_idx),
        .rt_data (rd_rt),
        .we      (rf_we),
        .wr_addr (rt_idx),
        .wr_data (wb_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_FETCH;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // Datapath registers: IR on handshake, ALU operands at end of DECODE so
    // they are stable for all of EXEC, result/address/store data at end of
    // EXEC, load data on ack. 'started' holds instr_ready low until the
    // first clock edge after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            started    <= 1'b0;
            ir         <= '0;
            alu_opcode <= '0;
            alu_rs     <= '0;
            alu_rt     <= '0;
            alu_imm    <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            wb_data    <= '0;
            wait_cnt   <= '0;
        end else begin
            started <= 1'b1;
            if (instr_ready && instr_valid) begin
                ir <= instr;
            end
            if (state == ST_DECODE) begin
                alu_opcode <= op;
                alu_rs     <= rd_rs;
                alu_rt     <= rd_rt;
                alu_imm    <= extend_imm(op, imm16);
            end
            if (state == ST_EXEC) begin
                mem_addr  <= alu_result;
                mem_wdata <= alu_rt;
                wb_data   <= alu_result;
                wait_cnt  <= '0;
            end
            if (state == ST_MEM) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
                if (mem_ack) begin
                    wb_data <= mem_rdata;
                end
            end
        end
    end

    // Next-state, PC update and control outputs. Early-terminating paths
    // (illegal opcode, branches, ADDI overflow, SW ack, bus timeout) retire
    // directly from their state and return to FETCH.
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        instr_ready = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        rf_we       = 1'b0;
        retire      = 1'b0;
        exc_code    = EXC_OK;

        case (state)
            ST_FETCH: begin
                instr_ready = started;
                if (started && instr_valid) begin
                    state_next = ST_DECODE;
                end
            end

            ST_DECODE: begin
                if (!is_legal(op)) begin
                    retire     = 1'b1;
                    exc_code   = EXC_ILLEGAL;
                    pc_next    = pc_plus4;
                    state_next = ST_FETCH;
                end else begin
                    state_next = ST_EXEC;
                end
            end

            ST_EXEC: begin
                if ((op == OP_BEQ) || (op == OP_BNE)) begin
                    retire     = 1'b1;
                    pc_next    = branch_taken ? branch_target : pc_plus4;
                    state_next = ST_FETCH;
                end else if ((op == OP_ADDI) && alu_overflow) begin
                    retire     = 1'b1;
                    exc_code   = EXC_OVERFLOW;
                    pc_next    = pc_plus4;
                    state_next = ST_FETCH;
                end else if ((op == OP_LW) || (op == OP_SW)) begin
                    state_next = ST_MEM;
                end else begin
                    state_next = ST_WB;
                end
            end

            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = (op == OP_SW);
                if (mem_ack) begin
                    if (op == OP_SW) begin
                        retire     = 1'b1;
                        pc_next    = pc_plus4;
                        state_next = ST_FETCH;
                    end else begin
                        state_next = ST_WB;
                    end
                end else if (wait_cnt == CNT_LAST) begin
                    retire     = 1'b1;
                    exc_code   = EXC_BUS_TMO;
                    pc_next    = pc_plus4;
                    state_next = ST_FETCH;
                end
            end

            ST_WB: begin
                rf_we      = 1'b1;
                retire     = 1'b1;
                pc_next    = pc_plus4;
                state_next = ST_FETCH;
            end

            default: begin
                state_next = ST_FETCH;
            end
        endcase
    end

endmodule
